// File: rtl/dvi_frame_capture.sv
// Captures a DVI pixel stream (VS/DE/RGB) into a double-buffered frame memory,
// decimating by integer steps. Banks swap only after a complete, well-formed
// frame; lock status and sticky geometry errors go to the control logic.
module dvi_frame_capture #(
  parameter int   H_ACTIVE = 128,
  parameter int   V_ACTIVE = 32,
  parameter int   OUT_W    = 128,
  parameter int   OUT_H    = 32,
  parameter logic VS_POL   = 1'b1,
  parameter int   AW       = $clog2(OUT_W * OUT_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          i_vs,
  input  logic          i_de,
  input  logic [7:0]    i_r,
  input  logic [7:0]    i_g,
  input  logic [7:0]    i_b,
  input  logic          err_clr,
  output logic          o_we,
  output logic          o_wr_bank,
  output logic [AW-1:0] o_waddr,
  output logic [23:0]   o_wdata,
  output logic          o_disp_bank,
  output logic          o_frame_done,
  output logic          o_locked,
  output logic          o_err
);

  localparam int H_STEP = H_ACTIVE / OUT_W;
  localparam int V_STEP = V_ACTIVE / OUT_H;
  localparam int XW  = $clog2(H_ACTIVE + 2);
  localparam int YW  = $clog2(V_ACTIVE + 2);
  localparam int HPW = $clog2(H_STEP + 1);
  localparam int VPW = $clog2(V_STEP + 1);
  localparam int XOW = $clog2(OUT_W + 1);

  localparam logic [XW-1:0]  X_ACT   = XW'(H_ACTIVE);
  localparam logic [XW-1:0]  X_SAT   = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0]  Y_ACT   = YW'(V_ACTIVE);
  localparam logic [YW-1:0]  Y_SAT   = YW'(V_ACTIVE + 1);
  localparam logic [HPW-1:0] HP_LAST = HPW'(H_STEP - 1);
  localparam logic [VPW-1:0] VP_LAST = VPW'(V_STEP - 1);
  localparam logic [AW-1:0]  ROW_INC = AW'(OUT_W);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FRAME = 1'b1;

  logic          vs_q, vs_prev, de_q, de_prev;
  logic [23:0]   rgb_q;
  logic [0:0]    state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [HPW-1:0] hph_reg, hph_next;
  logic [VPW-1:0] vph_reg, vph_next;
  logic [XOW-1:0] xo_reg, xo_next;
  logic [AW-1:0] row_base_reg, row_base_next;
  logic          bad_reg, bad_next;
  logic [1:0]    streak_reg, streak_next;
  logic          we_next;
  logic [AW-1:0] waddr_next;
  logic [23:0]   wdata_next;
  logic          good_frame, bad_frame;
  logic          frame_edge, line_end;

  assign frame_edge = (vs_q == VS_POL) && (vs_prev != VS_POL);
  assign line_end   = de_prev && !de_q;
  assign o_locked   = (streak_reg == 2'd2);

  // Input register stage plus one extra sample of VS/DE for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= ~VS_POL;
      vs_prev <= ~VS_POL;
      de_q    <= 1'b0;
      de_prev <= 1'b0;
      rgb_q   <= '0;
    end else begin
      vs_q    <= i_vs;
      vs_prev <= vs_q;
      de_q    <= i_de;
      de_prev <= de_q;
      rgb_q   <= {i_r, i_g, i_b};
    end
  end

  // Line end is applied first, then frame evaluation/restart, then the pixel,
  // so a pixel coinciding with a frame edge becomes (0,0) of the new frame.
  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    hph_next      = hph_reg;
    vph_next      = vph_reg;
    xo_next       = xo_reg;
    row_base_next = row_base_reg;
    bad_next      = bad_reg;
    streak_next   = streak_reg;
    we_next       = 1'b0;
    waddr_next    = o_waddr;
    wdata_next    = o_wdata;
    good_frame    = 1'b0;
    bad_frame     = 1'b0;
    if (!enable) begin
      state_next    = IDLE;
      x_next        = '0;
      y_next        = '0;
      hph_next      = '0;
      vph_next      = '0;
      xo_next       = '0;
      row_base_next = '0;
      bad_next      = 1'b0;
      streak_next   = 2'd0;
    end else begin
      if (state_reg == FRAME && line_end) begin
        if (x_reg != X_ACT) bad_next = 1'b1;
        if (y_reg < Y_ACT) begin
          if (vph_reg == VP_LAST) begin
            vph_next      = '0;
            row_base_next = row_base_reg + ROW_INC;
          end else begin
            vph_next = vph_reg + VPW'(1);
          end
        end
        if (y_reg != Y_SAT) y_next = y_reg + YW'(1);
        x_next   = '0;
        hph_next = '0;
        xo_next  = '0;
      end
      if (frame_edge) begin
        if (state_reg == FRAME) begin
          if (y_next == Y_ACT && !bad_next) begin
            good_frame  = 1'b1;
            streak_next = (streak_reg == 2'd2) ? 2'd2 : streak_reg + 2'd1;
          end else begin
            bad_frame   = 1'b1;
            streak_next = 2'd0;
          end
        end
        state_next    = FRAME;
        x_next        = '0;
        y_next        = '0;
        hph_next      = '0;
        vph_next      = '0;
        xo_next       = '0;
        row_base_next = '0;
        bad_next      = 1'b0;
      end
      if (state_next == FRAME && de_q) begin
        if (x_next < X_ACT && y_next < Y_ACT) begin
          if (hph_next == '0 && vph_next == '0) begin
            we_next    = 1'b1;
            waddr_next = row_base_next + AW'(xo_next);
            wdata_next = rgb_q;
          end
          if (hph_next == HP_LAST) begin
            hph_next = '0;
            xo_next  = xo_next + XOW'(1);
          end else begin
            hph_next = hph_next + HPW'(1);
          end
        end else begin
          bad_next = 1'b1;
        end
        if (x_next != X_SAT) x_next = x_next + XW'(1);
      end
    end
  end

  // Geometry counters, decimation phases and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      hph_reg      <= '0;
      vph_reg      <= '0;
      xo_reg       <= '0;
      row_base_reg <= '0;
      bad_reg      <= 1'b0;
      streak_reg   <= 2'd0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      hph_reg      <= hph_next;
      vph_reg      <= vph_next;
      xo_reg       <= xo_next;
      row_base_reg <= row_base_next;
      bad_reg      <= bad_next;
      streak_reg   <= streak_next;
    end
  end

  // Memory write port, bank swap on good frames, sticky error (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_wr_bank    <= 1'b0;
      o_disp_bank  <= 1'b1;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_we         <= we_next;
      o_waddr      <= waddr_next;
      o_wdata      <= wdata_next;
      o_frame_done <= good_frame;
      if (good_frame) begin
        o_disp_bank <= o_wr_bank;
        o_wr_bank   <= ~o_wr_bank;
      end
      if (bad_frame) o_err <= 1'b1;
      else if (err_clr) o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvi_frame_capture.sv
// Directed bench for dvi_frame_capture: default geometry plus a 64x16
// decimating instance sharing the same stimulus.
module tb_dvi_frame_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        i_vs = 1'b0;
  logic        i_de = 1'b0;
  logic [7:0]  i_r = '0, i_g = '0, i_b = '0;
  logic        err_clr = 1'b0;

  logic        o_we, o_wr_bank, o_disp_bank, o_frame_done, o_locked, o_err;
  logic [11:0] o_waddr;
  logic [23:0] o_wdata;
  logic        o_we2, o_wr_bank2, o_disp_bank2, o_frame_done2, o_locked2, o_err2;
  logic [9:0]  o_waddr2;
  logic [23:0] o_wdata2;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wcnt1 = 0, next_addr1 = 0, order_err1 = 0, data_err1 = 0, wcnt2 = 0;
  logic [23:0] d65 = '0;
  logic [23:0] exp_d;
  logic [3:0]  fdw;

  always #5 clk = ~clk;

  dvi_frame_capture dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i_vs(i_vs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .err_clr(err_clr),
    .o_we(o_we), .o_wr_bank(o_wr_bank), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_disp_bank(o_disp_bank), .o_frame_done(o_frame_done),
    .o_locked(o_locked), .o_err(o_err)
  );

  dvi_frame_capture #(.OUT_W(64), .OUT_H(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i_vs(i_vs), .i_de(i_de),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .err_clr(err_clr),
    .o_we(o_we2), .o_wr_bank(o_wr_bank2), .o_waddr(o_waddr2), .o_wdata(o_wdata2),
    .o_disp_bank(o_disp_bank2), .o_frame_done(o_frame_done2),
    .o_locked(o_locked2), .o_err(o_err2)
  );

  // Write monitor: counts writes, checks row-major order and {x,y,0x55} data.
  always @(negedge clk) begin
    if (o_we) begin
      wcnt1 = wcnt1 + 1;
      if (o_waddr !== 12'(next_addr1)) order_err1 = order_err1 + 1;
      next_addr1 = int'(o_waddr) + 1;
      exp_d = {8'(o_waddr % 128), 8'(o_waddr / 128), 8'h55};
      if (o_wdata !== exp_d) data_err1 = data_err1 + 1;
    end
    if (o_we2) begin
      wcnt2 = wcnt2 + 1;
      if (o_waddr2 == 10'd65) d65 = o_wdata2;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    wcnt1 = 0; next_addr1 = 0; order_err1 = 0; data_err1 = 0; wcnt2 = 0; d65 = '0;
  endtask

  task automatic send_line(input int npix, input int y);
    for (int x = 0; x < npix; x++) begin
      i_de = 1'b1; i_r = 8'(x); i_g = 8'(y); i_b = 8'h55;
      tick(1);
    end
    i_de = 1'b0;
    tick(4);
  endtask

  task automatic send_lines(input int nlines, input int short_line);
    for (int y = 0; y < nlines; y++) send_line((y == short_line) ? 127 : 128, y);
  endtask

  // VS pulse; returns o_frame_done sampled on four consecutive negedges.
  // A good frame shows up only in the third sample (after edge N+1).
  task automatic send_vs(output logic [3:0] fd, input logic clr);
    i_vs = 1'b1; i_de = 1'b0; err_clr = clr;
    @(negedge clk) fd[0] = o_frame_done;
    @(negedge clk) fd[1] = o_frame_done;
    @(negedge clk) fd[2] = o_frame_done;
    err_clr = 1'b0;
    @(negedge clk) fd[3] = o_frame_done;
    @(posedge clk); #1;
    i_vs = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    total_cnt++; if ({o_we, o_wr_bank, o_disp_bank, o_frame_done, o_locked, o_err} !== 6'b001000)
      $display("FAIL reset_flags got %b exp 001000", {o_we, o_wr_bank, o_disp_bank, o_frame_done, o_locked, o_err}); else pass_cnt++;
    total_cnt++; if (o_waddr !== 12'd0) $display("FAIL reset_waddr got %0d exp 0", o_waddr); else pass_cnt++;
    total_cnt++; if (o_wdata !== 24'd0) $display("FAIL reset_wdata got %h exp 0", o_wdata); else pass_cnt++;
  endtask

  task automatic test_clean_frames();
    logic exp_disp;
    enable = 1'b1;
    tick(2);
    send_vs(fdw, 1'b0);
    total_cnt++; if (fdw !== 4'b0000) $display("FAIL clean_first_edge fd got %b exp 0000", fdw); else pass_cnt++;
    for (int f = 1; f <= 3; f++) begin
      clr_mon();
      send_lines(32, -1);
      send_vs(fdw, 1'b0);
      exp_disp = (f % 2 == 1) ? 1'b0 : 1'b1;
      total_cnt++; if (fdw !== 4'b0100) $display("FAIL clean_fd f%0d got %b exp 0100", f, fdw); else pass_cnt++;
      total_cnt++; if (wcnt1 !== 4096) $display("FAIL clean_wcnt f%0d got %0d exp 4096", f, wcnt1); else pass_cnt++;
      total_cnt++; if (order_err1 !== 0) $display("FAIL clean_order f%0d got %0d bad exp 0", f, order_err1); else pass_cnt++;
      total_cnt++; if (data_err1 !== 0) $display("FAIL clean_data f%0d got %0d bad exp 0", f, data_err1); else pass_cnt++;
      total_cnt++; if (wcnt2 !== 1024) $display("FAIL dec_wcnt f%0d got %0d exp 1024", f, wcnt2); else pass_cnt++;
      total_cnt++; if (d65 !== 24'h020255) $display("FAIL dec_addr65 f%0d got %h exp 020255", f, d65); else pass_cnt++;
      total_cnt++; if (o_disp_bank !== exp_disp) $display("FAIL clean_disp f%0d got %b exp %b", f, o_disp_bank, exp_disp); else pass_cnt++;
      total_cnt++; if (o_wr_bank !== ~exp_disp) $display("FAIL clean_wr f%0d got %b exp %b", f, o_wr_bank, ~exp_disp); else pass_cnt++;
      total_cnt++; if (o_locked !== (f >= 2)) $display("FAIL clean_locked f%0d got %b exp %b", f, o_locked, (f >= 2)); else pass_cnt++;
    end
  endtask

  task automatic test_short_line();
    clr_mon();
    send_lines(32, 5);
    send_vs(fdw, 1'b0);
    total_cnt++; if (fdw !== 4'b0000) $display("FAIL short_fd got %b exp 0000", fdw); else pass_cnt++;
    total_cnt++; if (wcnt1 !== 4095) $display("FAIL short_wcnt got %0d exp 4095", wcnt1); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b1) $display("FAIL short_err got %b exp 1", o_err); else pass_cnt++;
    total_cnt++; if ({o_wr_bank, o_disp_bank} !== 2'b10) $display("FAIL short_banks got %b exp 10", {o_wr_bank, o_disp_bank}); else pass_cnt++;
    total_cnt++; if (o_locked !== 1'b0) $display("FAIL short_locked got %b exp 0", o_locked); else pass_cnt++;
    clr_mon();
    send_lines(32, -1);
    send_vs(fdw, 1'b0);
    total_cnt++; if (fdw !== 4'b0100) $display("FAIL recover_fd got %b exp 0100", fdw); else pass_cnt++;
    total_cnt++; if ({o_wr_bank, o_disp_bank} !== 2'b01) $display("FAIL recover_banks got %b exp 01", {o_wr_bank, o_disp_bank}); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b1) $display("FAIL recover_err_sticky got %b exp 1", o_err); else pass_cnt++;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    total_cnt++; if (o_err !== 1'b0) $display("FAIL err_clr got %b exp 0", o_err); else pass_cnt++;
  endtask

  task automatic test_extra_line();
    clr_mon();
    send_lines(33, -1);
    total_cnt++; if (wcnt1 !== 4096) $display("FAIL extra_wcnt got %0d exp 4096", wcnt1); else pass_cnt++;
    total_cnt++; if (order_err1 !== 0) $display("FAIL extra_order got %0d exp 0", order_err1); else pass_cnt++;
    send_vs(fdw, 1'b0);
    total_cnt++; if (fdw !== 4'b0000) $display("FAIL extra_fd got %b exp 0000", fdw); else pass_cnt++;
    total_cnt++; if (o_err !== 1'b1) $display("FAIL extra_err got %b exp 1", o_err); else pass_cnt++;
    total_cnt++; if ({o_wr_bank, o_disp_bank} !== 2'b01) $display("FAIL extra_banks got %b exp 01", {o_wr_bank, o_disp_bank}); else pass_cnt++;
  endtask

  task automatic test_enable();
    send_lines(32, -1);
    send_vs(fdw, 1'b0);
    send_lines(32, -1);
    send_vs(fdw, 1'b0);
    total_cnt++; if (o_locked !== 1'b1) $display("FAIL en_prelock got %b exp 1", o_locked); else pass_cnt++;
    total_cnt++; if ({o_wr_bank, o_disp_bank} !== 2'b01) $display("FAIL en_prebanks got %b exp 01", {o_wr_bank, o_disp_bank}); else pass_cnt++;
    send_lines(3, -1);
    for (int x = 0; x < 20; x++) begin
      i_de = 1'b1; i_r = 8'(x); i_g = 8'd3; i_b = 8'h55;
      tick(1);
    end
    total_cnt++; if (o_we !== 1'b1) $display("FAIL en_streaming got %b exp 1", o_we); else pass_cnt++;
    enable = 1'b0;
    i_r = 8'd20;
    tick(1);
    total_cnt++; if (o_we !== 1'b0) $display("FAIL en_off_we got %b exp 0", o_we); else pass_cnt++;
    total_cnt++; if (o_locked !== 1'b0) $display("FAIL en_off_locked got %b exp 0", o_locked); else pass_cnt++;
    total_cnt++; if (o_disp_bank !== 1'b1) $display("FAIL en_off_disp got %b exp 1", o_disp_bank); else pass_cnt++;
    clr_mon();
    i_de = 1'b0;
    tick(2);
    send_lines(2, -1);
    enable = 1'b1;
    send_lines(2, -1);
    total_cnt++; if (wcnt1 !== 0) $display("FAIL en_idle_writes got %0d exp 0", wcnt1); else pass_cnt++;
    send_vs(fdw, 1'b0);
    total_cnt++; if (fdw !== 4'b0000) $display("FAIL en_restart_fd got %b exp 0000", fdw); else pass_cnt++;
    clr_mon();
    send_lines(32, -1);
    send_vs(fdw, 1'b0);
    total_cnt++; if (fdw !== 4'b0100) $display("FAIL en_resume_fd got %b exp 0100", fdw); else pass_cnt++;
    total_cnt++; if (wcnt1 !== 4096) $display("FAIL en_resume_wcnt got %0d exp 4096", wcnt1); else pass_cnt++;
    total_cnt++; if ({o_wr_bank, o_disp_bank, o_locked} !== 3'b100) $display("FAIL en_resume_state got %b exp 100", {o_wr_bank, o_disp_bank, o_locked}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // Leave o_err set so the asynchronous reset has something to clear.
    send_lines(2, -1);
    send_vs(fdw, 1'b0);
    total_cnt++; if (o_err !== 1'b1) $display("FAIL rst_pre_err got %b exp 1", o_err); else pass_cnt++;
    for (int x = 0; x < 10; x++) begin
      i_de = 1'b1; i_r = 8'(x); i_g = 8'd0; i_b = 8'h55;
      tick(1);
    end
    total_cnt++; if (o_we !== 1'b1) $display("FAIL rst_pre_we got %b exp 1", o_we); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({o_we, o_wr_bank, o_disp_bank, o_frame_done, o_locked, o_err} !== 6'b001000)
      $display("FAIL rst_mid_flags got %b exp 001000", {o_we, o_wr_bank, o_disp_bank, o_frame_done, o_locked, o_err}); else pass_cnt++;
    total_cnt++; if (o_waddr !== 12'd0) $display("FAIL rst_mid_waddr got %0d exp 0", o_waddr); else pass_cnt++;
    total_cnt++; if (o_wdata !== 24'd0) $display("FAIL rst_mid_wdata got %h exp 0", o_wdata); else pass_cnt++;
    i_de = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_vs(fdw, 1'b0);
    send_lines(2, -1);
    send_vs(fdw, 1'b0);
    total_cnt++; if (o_err !== 1'b1) $display("FAIL rst_bad_err got %b exp 1", o_err); else pass_cnt++;
    send_lines(2, -1);
    send_vs(fdw, 1'b1);
    total_cnt++; if (o_err !== 1'b1) $display("FAIL clr_vs_err got %b exp 1", o_err); else pass_cnt++;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    total_cnt++; if (o_err !== 1'b0) $display("FAIL final_clr got %b exp 0", o_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_short_line();
    test_extra_line();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
